flag_unit: RTL and testbench

Producer side of the 3-bit condition-flag bus consumed by the branch-condition evaluator. The unit computes Zero, Overflow and Sign from the ALU result in EX and masks the update per opcode. It holds the architectural flag register and presents the flags a branch in ID must see, either bypassed from EX or guarded by a one-cycle hazard stall. Bus packing is fixed: Z = bit2, V = bit1, N = bit0.

---
 rtl/flag_unit_if.sv | 25 ++
 rtl/flag_unit.sv | 68 ++++++
 tb/tb_flag_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/flag_unit_if.sv
// Condition-flag bus bundle between the EX/ID pipeline control and flag_unit.
// Carries the EX-stage flag inputs, the ID branch request and the three flag results.
// The master modport drives EX/ID status. The slave modport (flag_unit) returns the flags.
interface flag_unit_if;
    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic [15:0] alu_result;
    logic        alu_ovfl;
    logic        stall;
    logic        flush;
    logic        id_is_branch;
    logic [2:0]  flags_out;
    logic [2:0]  flags_fwd;
    logic        flag_hazard;

    modport master (
        output ex_valid, ex_opcode, alu_result, alu_ovfl, stall, flush, id_is_branch,
        input  flags_out, flags_fwd, flag_hazard
    );

    modport slave (
        input  ex_valid, ex_opcode, alu_result, alu_ovfl, stall, flush, id_is_branch,
        output flags_out, flags_fwd, flag_hazard
    );
endinterface

// File: rtl/flag_unit.sv
// Condition-flag producer: computes {Z,V,N} in EX, masks per opcode, holds the flag register.
// Latency: flags_out updates 1 cycle after a qualifying EX writer; flags_fwd is combinational.
// Backpressure: stall holds the writer; flush discards it. Without FLAG_BYPASS_EN, flag_hazard stalls the ID branch.
// Build option: define FLAG_BYPASS_EN to forward next-cycle flags to ID and remove the hazard stall.
module flag_unit (
    input  logic        clk,
    input  logic        rst,
    flag_unit_if.slave  bus
);
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;

    // Bit positions on the flag bus: Z = 2, V = 1, N = 0
    logic [2:0] r_flag;
    logic [2:0] w_mask_raw;
    logic [2:0] w_mask_q;
    logic [2:0] w_computed;
    logic [2:0] w_next;
    logic       w_wr_qual;

    // Per-opcode write mask before qualification
    always_comb begin
        w_mask_raw = 3'b000;
        case (bus.ex_opcode)
            OP_ADD, OP_SUB:         w_mask_raw = 3'b111;
            OP_XOR:                 w_mask_raw = 3'b100;
            OP_SLL, OP_SRA, OP_ROR: w_mask_raw = 3'b100;
            default:                w_mask_raw = 3'b000;
        endcase
    end

    // A flag write happens only for a live, retiring, unsquashed EX instruction
    assign w_wr_qual  = bus.ex_valid & ~bus.stall & ~bus.flush;
    assign w_mask_q   = w_wr_qual ? w_mask_raw : 3'b000;
    assign w_computed = {(bus.alu_result == 16'h0000), bus.alu_ovfl, bus.alu_result[15]};

    // Unmasked bits keep their previous value; this is what r_flag holds after the edge
    assign w_next = (w_mask_q & w_computed) | (~w_mask_q & r_flag);

    // Architectural flag register; async reset clears it and drops any in-flight write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flag <= 3'b000;
        end else begin
            r_flag <= w_next;
        end
    end

    assign bus.flags_out = r_flag;

`ifdef FLAG_BYPASS_EN
    // Branch in ID sees the value the EX writer is about to commit, so no stall is needed
    logic w_unused_br;
    assign w_unused_br     = bus.id_is_branch;
    assign bus.flags_fwd   = rst ? 3'b000 : w_next;
    assign bus.flag_hazard = 1'b0;
`else
    // Stall ignores the hazard so a held writer keeps the branch stalled until it commits
    assign bus.flags_fwd   = r_flag;
    assign bus.flag_hazard = ~rst & bus.id_is_branch & bus.ex_valid & ~bus.flush
                             & (w_mask_raw != 3'b000);
`endif

endmodule

// File: tb/tb_flag_unit.sv
// Directed-vector bench for flag_unit with a queue-based scoreboard.
// Each vector is one cycle of EX/ID inputs; its expected outputs are pushed when driven.
// A negedge monitor pops and compares; expectations cover both bypass configurations.
module tb_flag_unit;
    logic clk;
    logic rst;

    flag_unit_if bus ();

    flag_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, XOR = 4'h2, SLL = 4'h4,
                           SRA = 4'h5, ROR = 4'h6, LW = 4'h8, PCS = 4'hE;

    typedef struct packed {
        logic [1:0]  rst_at;   // 0: rst low, 1: high all cycle, 2: rises mid-cycle
        logic        vld;
        logic [3:0]  opc;
        logic [15:0] res;
        logic        ovfl;
        logic        stl;
        logic        fl;
        logic        br;
        logic [2:0]  e_out;
        logic [2:0]  e_fwd_b;  // flags_fwd with bypass
        logic [2:0]  e_fwd_n;  // flags_fwd without bypass
        logic        e_haz_n;  // flag_hazard without bypass
    } vec_t;

    typedef struct {
        int         idx;
        logic [2:0] out;
        logic [2:0] fwd;
        logic       haz;
    } exp_t;

    vec_t vecs[$];
    exp_t expq[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic add(input logic [1:0] rst_at, input logic vld, input logic [3:0] opc,
                       input logic [15:0] res, input logic ovfl, input logic stl,
                       input logic fl, input logic br, input logic [2:0] e_out,
                       input logic [2:0] e_fb, input logic [2:0] e_fn, input logic e_hn);
        vec_t v;
        v = '{rst_at, vld, opc, res, ovfl, stl, fl, br, e_out, e_fb, e_fn, e_hn};
        vecs.push_back(v);
    endtask

    // Monitor: compare every presented cycle against the oldest pending expectation
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            n_vec++;
            if (bus.flags_out !== e.out) begin
                n_miss++;
                $display("FAIL v%0d flags_out got %b want %b", e.idx, bus.flags_out, e.out);
            end
            if (bus.flags_fwd !== e.fwd) begin
                n_miss++;
                $display("FAIL v%0d flags_fwd got %b want %b", e.idx, bus.flags_fwd, e.fwd);
            end
            if (bus.flag_hazard !== e.haz) begin
                n_miss++;
                $display("FAIL v%0d flag_hazard got %b want %b", e.idx, bus.flag_hazard, e.haz);
            end
        end
    end

    initial begin
        rst              = 1'b1;
        bus.ex_valid     = 1'b0;
        bus.ex_opcode    = 4'h0;
        bus.alu_result   = 16'h0;
        bus.alu_ovfl     = 1'b0;
        bus.stall        = 1'b0;
        bus.flush        = 1'b0;
        bus.id_is_branch = 1'b0;

        //   rst vld opc  res      ov st fl br  out     fwd_byp fwd_nob haz
        add(1, 1, ADD, 16'h8000, 1, 0, 0, 1, 3'b000, 3'b000, 3'b000, 0); // 0 held in reset
        add(0, 0, ADD, 16'h0000, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0); // 1 no update during rst
        add(0, 1, ADD, 16'h8000, 1, 0, 0, 0, 3'b000, 3'b011, 3'b000, 0); // 2
        add(0, 1, SUB, 16'h0000, 0, 0, 0, 0, 3'b011, 3'b100, 3'b011, 0); // 3
        add(0, 1, ADD, 16'h8000, 1, 0, 0, 0, 3'b100, 3'b011, 3'b100, 0); // 4
        add(0, 1, XOR, 16'h0000, 0, 0, 0, 0, 3'b011, 3'b111, 3'b011, 0); // 5 V,N held
        add(0, 1, LW,  16'h0000, 0, 0, 0, 0, 3'b111, 3'b111, 3'b111, 0); // 6 no mask
        add(0, 0, ADD, 16'h0000, 0, 0, 0, 0, 3'b111, 3'b111, 3'b111, 0); // 7
        add(0, 1, ADD, 16'h8000, 0, 0, 0, 0, 3'b111, 3'b001, 3'b111, 0); // 8
        add(0, 1, ADD, 16'h0000, 0, 1, 1, 1, 3'b001, 3'b001, 3'b001, 0); // 9 stall+flush
        add(0, 1, ADD, 16'h0000, 0, 1, 0, 1, 3'b001, 3'b001, 3'b001, 1); // 10 stall
        add(0, 1, ADD, 16'h0000, 0, 1, 0, 1, 3'b001, 3'b001, 3'b001, 1); // 11 stall
        add(0, 1, ADD, 16'h0000, 0, 0, 0, 1, 3'b001, 3'b100, 3'b001, 1); // 12 released
        add(0, 0, ADD, 16'h0000, 0, 0, 0, 1, 3'b100, 3'b100, 3'b100, 0); // 13 bubble
        add(0, 1, ADD, 16'h8000, 1, 0, 0, 0, 3'b100, 3'b011, 3'b100, 0); // 14
        add(0, 1, ADD, 16'h0000, 0, 0, 0, 1, 3'b011, 3'b100, 3'b011, 1); // 15 branch behind writer
        add(0, 0, ADD, 16'h0000, 0, 0, 0, 1, 3'b100, 3'b100, 3'b100, 0); // 16 bubble
        add(0, 1, SLL, 16'h8000, 1, 0, 0, 0, 3'b100, 3'b000, 3'b100, 0); // 17 Z only
        add(0, 1, ROR, 16'h0000, 0, 0, 0, 0, 3'b000, 3'b100, 3'b000, 0); // 18
        add(0, 1, PCS, 16'h0000, 1, 0, 0, 1, 3'b100, 3'b100, 3'b100, 0); // 19 non-writer branch
        add(0, 1, SRA, 16'h1234, 1, 0, 0, 0, 3'b100, 3'b000, 3'b100, 0); // 20
        add(0, 1, ADD, 16'h0000, 0, 0, 1, 1, 3'b000, 3'b000, 3'b000, 0); // 21 flush only
        add(0, 1, ADD, 16'h8000, 1, 0, 0, 0, 3'b000, 3'b011, 3'b000, 0); // 22
        add(0, 1, XOR, 16'h0000, 0, 0, 0, 0, 3'b011, 3'b111, 3'b011, 0); // 23
        add(0, 0, ADD, 16'h0000, 0, 0, 0, 0, 3'b111, 3'b111, 3'b111, 0); // 24 preload 111
        add(2, 1, ADD, 16'h8000, 1, 0, 0, 1, 3'b000, 3'b000, 3'b000, 0); // 25 async reset
        add(1, 1, ADD, 16'h0000, 0, 0, 0, 1, 3'b000, 3'b000, 3'b000, 0); // 26 edge under rst
        add(0, 1, ADD, 16'h8000, 1, 0, 0, 0, 3'b000, 3'b011, 3'b000, 0); // 27
        add(0, 0, ADD, 16'h0000, 0, 0, 0, 0, 3'b011, 3'b011, 3'b011, 0); // 28 first update after rst

        foreach (vecs[i]) begin
            vec_t v;
            exp_t e;
            v = vecs[i];
            @(posedge clk);
            #1;
            rst              = (v.rst_at == 2'd1);
            bus.ex_valid     = v.vld;
            bus.ex_opcode    = v.opc;
            bus.alu_result   = v.res;
            bus.alu_ovfl     = v.ovfl;
            bus.stall        = v.stl;
            bus.flush        = v.fl;
            bus.id_is_branch = v.br;
            e.idx = i;
            e.out = v.e_out;
`ifdef FLAG_BYPASS_EN
            e.fwd = v.e_fwd_b;
            e.haz = 1'b0;
`else
            e.fwd = v.e_fwd_n;
            e.haz = v.e_haz_n;
`endif
            expq.push_back(e);
            if (v.rst_at == 2'd2) begin
                #2;
                rst = 1'b1;
            end
        end

        for (int k = 0; k < 10 && expq.size() > 0; k++) @(negedge clk);
        #1;
        if (expq.size() > 0) begin
            n_miss++;
            $display("FAIL drain pending %0d want 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
